bcd_up_down_counter: RTL and testbench

Multi-digit BCD counter that produces the digit codes and digit enables consumed by the per-digit BCD-to-7-segment decoders.
- Counts up or down at a prescaled tick rate, with start/stop, synchronous clear and parallel load.
- Wraps at a programmable modulus and emits a one-cycle carry/borrow pulse for cascading.
- Optionally blanks leading zeros by deasserting the per-digit decoder enable.

---
 rtl/bcd_pkg.sv | 30 +++
 rtl/bcd_digit.sv | 38 +++
 rtl/bcd_up_down_counter.sv | 143 ++++++++++++++
 tb/tb_bcd_up_down_counter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, digit constants and elaboration helpers.
`default_nettype none

package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX  = 4'd9;
   localparam bcd_digit_t BCD_ZERO = 4'd0;

   // Converts a non-negative integer into up to eight packed BCD digits.
   function automatic logic [31:0] int_to_bcd(input int value);
      int          v;
      logic [31:0] r;
      v = value;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic bcd_valid(input bcd_digit_t d);
      return (d <= BCD_MAX);
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
// bcd_digit: combinational single-digit BCD incrementer/decrementer with ripple in/out.
`default_nettype none

module bcd_digit
   import bcd_pkg::*;
(
   input  bcd_digit_t digit,
   input  logic       up,
   input  logic       cin,
   output bcd_digit_t next,
   output logic       cout
);

   always_comb begin
      next = digit;
      cout = 1'b0;
      if (cin) begin
         if (up) begin
            if (digit >= BCD_MAX) begin
               next = BCD_ZERO;
               cout = 1'b1;
            end else begin
               next = digit + 4'd1;
            end
         end else begin
            if (digit == BCD_ZERO) begin
               next = BCD_MAX;
               cout = 1'b1;
            end else begin
               next = digit - 4'd1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/bcd_up_down_counter.sv
// bcd_up_down_counter: prescaled multi-digit BCD up/down counter with programmable
// modulus, wrap pulse, validated parallel load and leading-zero blanking.
`default_nettype none

module bcd_up_down_counter
   import bcd_pkg::*;
#(
   parameter int NDIG      = 2,
   parameter int MAX_COUNT = 59,
   parameter int DIV       = 50_000_000,
   parameter int LZB       = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_stop,
   input  logic              clr,
   input  logic              load,
   input  logic [4*NDIG-1:0] load_val,
   input  logic              up,
   output logic [4*NDIG-1:0] bcd_out,
   output logic [NDIG-1:0]   dig_en,
   output logic              carry,
   output logic              running,
   output logic              load_err
);

   localparam int                PW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [31:0]       MAX_FULL  = int_to_bcd(MAX_COUNT);
   localparam logic [4*NDIG-1:0] MAX_BCD   = MAX_FULL[4*NDIG-1:0];
   localparam logic [PW-1:0]     PRESC_TOP = PW'(DIV - 1);
   localparam logic [NDIG-1:0]   EN_RESET  = (LZB != 0) ? NDIG'(1) : {NDIG{1'b1}};

   typedef enum logic {
      STOPPED = 1'b0,
      RUNNING = 1'b1
   } state_t;

   state_t            state;
   logic [PW-1:0]     presc;
   logic [PW-1:0]     presc_nxt;
   logic [4*NDIG-1:0] step;
   logic [4*NDIG-1:0] count_nxt;
   logic [NDIG:0]     rip;
   logic [NDIG-1:0]   en_nxt;
   logic              carry_nxt;
   logic              err_nxt;
   logic              load_ok;
   logic              wrap;
   logic              any_hi;

   assign rip[0] = 1'b1;

   generate
      for (genvar i = 0; i < NDIG; i++) begin : g_dig
         bcd_digit u_digit (
            .digit (bcd_out[4*i +: 4]),
            .up    (up),
            .cin   (rip[i]),
            .next  (step[4*i +: 4]),
            .cout  (rip[i+1])
         );
      end
   endgenerate

   // A ripple out of the top digit while counting down means every digit was zero.
   assign wrap = up ? (bcd_out == MAX_BCD) : rip[NDIG];

   always_comb begin
      load_ok = (load_val <= MAX_BCD);
      for (int i = 0; i < NDIG; i++) begin
         if (!bcd_valid(load_val[4*i +: 4])) begin
            load_ok = 1'b0;
         end
      end
   end

   always_comb begin
      count_nxt = bcd_out;
      presc_nxt = presc;
      carry_nxt = 1'b0;
      err_nxt   = 1'b0;
      if (clr) begin
         count_nxt = '0;
         presc_nxt = '0;
      end else if (load) begin
         if (load_ok) begin
            count_nxt = load_val;
            presc_nxt = '0;
         end else begin
            err_nxt = 1'b1;
         end
      end else if (state == RUNNING) begin
         if (presc == PRESC_TOP) begin
            presc_nxt = '0;
            carry_nxt = wrap;
            if (wrap) begin
               count_nxt = up ? '0 : MAX_BCD;
            end else begin
               count_nxt = step;
            end
         end else begin
            presc_nxt = presc + PW'(1);
         end
      end
   end

   always_comb begin
      en_nxt    = {NDIG{1'b1}};
      any_hi    = 1'b0;
      for (int i = NDIG - 1; i > 0; i--) begin
         any_hi    = any_hi | (count_nxt[4*i +: 4] != BCD_ZERO);
         en_nxt[i] = any_hi | (LZB == 0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= STOPPED;
         running  <= 1'b0;
         presc    <= '0;
         bcd_out  <= '0;
         dig_en   <= EN_RESET;
         carry    <= 1'b0;
         load_err <= 1'b0;
      end else begin
         presc    <= presc_nxt;
         bcd_out  <= count_nxt;
         dig_en   <= en_nxt;
         carry    <= carry_nxt;
         load_err <= err_nxt;
         if (clr) begin
            state   <= STOPPED;
            running <= 1'b0;
         end else if (start_stop) begin
            state   <= (state == RUNNING) ? STOPPED : RUNNING;
            running <= (state == STOPPED);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bcd_up_down_counter.sv
// tb_bcd_up_down_counter: directed scenarios plus random stimulus checked every
// cycle against an integer-valued reference model.
`default_nettype none

module tb_bcd_up_down_counter;

   localparam int NDIG = 2;
   localparam int MAXC = 59;
   localparam int DIV  = 4;
   localparam int LZB  = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_stop = 1'b0;
   logic       clr = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_val = 8'h00;
   logic       up = 1'b1;
   logic [7:0] bcd_out;
   logic [1:0] dig_en;
   logic       carry;
   logic       running;
   logic       load_err;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: count as a plain integer.
   int m_val = 0;
   int m_presc = 0;
   bit m_run = 0;
   bit m_carry = 0;
   bit m_err = 0;

   bcd_up_down_counter #(
      .NDIG      (NDIG),
      .MAX_COUNT (MAXC),
      .DIV       (DIV),
      .LZB       (LZB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_stop (start_stop),
      .clr        (clr),
      .load       (load),
      .load_val   (load_val),
      .up         (up),
      .bcd_out    (bcd_out),
      .dig_en     (dig_en),
      .carry      (carry),
      .running    (running),
      .load_err   (load_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   task automatic model_clock();
      int  lv_dec;
      bit  lv_ok;
      m_carry = 0;
      m_err   = 0;
      if (!rst_n) begin
         m_val = 0; m_presc = 0; m_run = 0;
      end else if (clr) begin
         m_val = 0; m_presc = 0; m_run = 0;
      end else begin
         if (load) begin
            lv_dec = int'(load_val[7:4]) * 10 + int'(load_val[3:0]);
            lv_ok  = (load_val[7:4] <= 9) && (load_val[3:0] <= 9) && (lv_dec <= MAXC);
            if (lv_ok) begin
               m_val = lv_dec; m_presc = 0;
            end else begin
               m_err = 1;
            end
         end else if (m_run) begin
            if (m_presc == DIV - 1) begin
               m_presc = 0;
               if (up) begin
                  if (m_val == MAXC) begin m_val = 0; m_carry = 1; end
                  else m_val = m_val + 1;
               end else begin
                  if (m_val == 0) begin m_val = MAXC; m_carry = 1; end
                  else m_val = m_val - 1;
               end
            end else begin
               m_presc = m_presc + 1;
            end
         end
         if (start_stop) m_run = !m_run;
      end
   endtask

   // Apply inputs, clock once, then compare every output with the model.
   task automatic cyc(input bit rn, input bit ss, input bit cl, input bit ld,
                      input logic [7:0] lv, input bit u);
      rst_n = rn; start_stop = ss; clr = cl; load = ld; load_val = lv; up = u;
      @(posedge clk);
      model_clock();
      #1;
      check("bcd_out", bcd_out, to_bcd(m_val));
      check("dig_en", dig_en, {1'b0, (m_val >= 10), 1'b1} & 2'b11);
      check("carry", carry, m_carry);
      check("running", running, m_run);
      check("load_err", load_err, m_err);
      check("nibble_lo", bcd_out[3:0] <= 4'd9, 1);
      check("nibble_hi", bcd_out[7:4] <= 4'd9, 1);
      start_stop = 0; clr = 0; load = 0;
   endtask

   task automatic idle(input int n, input bit u);
      for (int k = 0; k < n; k++) cyc(1, 0, 0, 0, 8'h00, u);
   endtask

   initial begin
      int v;
      // 1: reset, start, count up through 10
      cyc(0, 0, 0, 0, 8'h00, 1);
      check("reset_cnt", bcd_out, 8'h00);
      check("reset_en", dig_en, 2'b01);
      cyc(1, 1, 0, 0, 8'h00, 1);
      idle(40, 1);
      check("t1_reach10", bcd_out, 8'h10);
      check("t1_en", dig_en, 2'b11);
      // 2: load 58 and wrap up
      cyc(1, 0, 0, 1, 8'h58, 1);
      check("t2_load", bcd_out, 8'h58);
      idle(8, 1);
      check("t2_wrap", bcd_out, 8'h00);
      check("t2_en", dig_en, 2'b01);
      // 3: wrap down from 00
      idle(4, 0);
      check("t3_down_wrap", bcd_out, 8'h59);
      idle(4, 0);
      check("t3_down", bcd_out, 8'h58);
      // 4: rejected and accepted loads while stopped
      cyc(1, 1, 0, 0, 8'h00, 1);
      cyc(1, 0, 0, 1, 8'h6A, 1);
      check("t4_err_6a", load_err, 1);
      cyc(1, 0, 0, 1, 8'h60, 1);
      check("t4_err_60", load_err, 1);
      check("t4_hold", bcd_out, 8'h58);
      cyc(1, 0, 0, 1, 8'h45, 1);
      check("t4_load45", bcd_out, 8'h45);
      check("t4_noerr", load_err, 0);
      // 5: clr beats concurrent load and start_stop
      cyc(1, 1, 0, 1, 8'h37, 1);
      idle(2, 1);
      cyc(1, 1, 1, 1, 8'h12, 1);
      check("t5_clr", bcd_out, 8'h00);
      check("t5_stop", running, 0);
      cyc(1, 1, 0, 0, 8'h00, 1);
      idle(4, 1);
      check("t5_resume", bcd_out, 8'h01);
      // 6: reset mid-run
      cyc(1, 0, 0, 1, 8'h23, 1);
      idle(2, 1);
      cyc(0, 0, 0, 0, 8'h00, 1);
      check("t6_rst_cnt", bcd_out, 8'h00);
      check("t6_rst_run", running, 0);
      check("t6_rst_en", dig_en, 2'b01);
      // Random traffic
      cyc(1, 1, 0, 0, 8'h00, 1);
      for (int k = 0; k < 1500; k++) begin
         v = int'($urandom_range(0, 69));
         cyc(($urandom_range(0, 99) != 0),
             ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 39) == 0),
             ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 1) == 0) ? 8'($urandom) : to_bcd(v),
             (k / 97) % 2 == 0);
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
